// File: rtl/fft_frame_packer.sv
// Collects a serial stream of real samples into 16-slot complex frames for the
// parallel FFT; the next frame fills a separate buffer while the last one is held.
module fft_frame_packer #(
   parameter int N  = 16,
   parameter int DW = 16,
   parameter int CW = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 smp_valid,
   input  logic signed [DW-1:0] smp_data,
   input  logic                 frm_clr,
   output logic                 frm_valid,
   output logic [N*2*DW-1:0]    frm_data,
   output logic [CW-1:0]        frm_cnt,
   output logic [4:0]           fill_lvl
);

   localparam int PW = $clog2(N);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PW-1:0]        r_wp;
   logic signed [DW-1:0] r_buf [N];
   logic                 r_frm_valid;
   logic [N*2*DW-1:0]    r_frm_data;
   logic [CW-1:0]        r_frm_cnt;
   logic [N*2*DW-1:0]    w_frame;
   logic                 w_take;
   logic                 w_last;
   logic                 w_done;

   function automatic logic [2*DW-1:0] pack_slot(input logic signed [DW-1:0] s);
      return {s, {DW{1'b0}}};
   endfunction

   assign w_take = smp_valid & ~frm_clr;
   assign w_last = (r_wp == PW'(N-1));
   assign w_done = w_take & w_last;

   // The slot under the write pointer takes the live sample so the completing
   // sample lands in the frame on the same edge it is accepted.
   always_comb begin
      w_frame = '0;
      for (int k = 0; k < N; k++) begin
         w_frame[k*2*DW +: 2*DW] = (r_wp == PW'(k)) ? pack_slot(smp_data)
                                                     : pack_slot(r_buf[k]);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_take) w_state_nxt = S_FILL;
         S_FILL:  if (w_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (frm_clr) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_wp        <= '0;
         r_frm_valid <= 1'b0;
         r_frm_data  <= '0;
         r_frm_cnt   <= '0;
         for (int k = 0; k < N; k++) r_buf[k] <= '0;
      end else begin
         r_frm_valid <= w_done;
         if (frm_clr) begin
            r_wp <= '0;
         end else if (smp_valid) begin
            r_buf[r_wp] <= smp_data;
            r_wp        <= r_wp + PW'(1);
            if (w_last) begin
               r_frm_data <= w_frame;
               r_frm_cnt  <= r_frm_cnt + CW'(1);
            end
         end
      end
   end

   assign frm_valid = r_frm_valid;
   assign frm_data  = r_frm_data;
   assign frm_cnt   = r_frm_cnt;
   assign fill_lvl  = 5'(r_wp);

endmodule
